sccb_config_sequencer: RTL

Parametrised successor to the fixed camera register ROM. It walks a register table selected at start time and issues one SCCB write per entry to the SCCB master over a valid/ready command channel. It honours the end (16'hFFFF) and delay (16'hFFF0) markers, retries NACKed writes, and reports done/error status with a failing index. It sits between the external synchronous config ROM (1-cycle read latency, `{reg_addr[15:8], value[7:0]}` words) and the SCCB master.

---
 rtl/sccb_config_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sccb_config_sequencer.sv
`timescale 1ns/1ps
// Walks a selected camera register table from a synchronous ROM and issues one
// SCCB write per entry, honouring end/delay markers and retrying NACKed writes.
module sccb_config_sequencer #(
  parameter int unsigned IDX_W        = 8,
  parameter int unsigned TSEL_W       = 1,
  parameter int unsigned DELAY_CYCLES = 240000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [15:0] END_WORD     = 16'hFFFF,
  parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [TSEL_W-1:0]        table_sel,
  output logic [TSEL_W+IDX_W-1:0]  rom_addr,
  input  logic [15:0]              rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_reg,
  output logic [7:0]               cmd_data,
  input  logic                     rsp_valid,
  input  logic                     rsp_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         fail_index,
  output logic [IDX_W:0]           writes_ok
);

  localparam int unsigned ADDR_W = TSEL_W + IDX_W;
  localparam int unsigned RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned DCNT_W = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT_RSP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr_nxt;
  logic                r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0]          r_cmd_reg, w_cmd_reg_nxt;
  logic [7:0]          r_cmd_data, w_cmd_data_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic [IDX_W-1:0]    r_fail_index, w_fail_index_nxt;
  logic [IDX_W:0]      r_writes_ok, w_writes_ok_nxt;
  logic [RTRY_W-1:0]   r_retry, w_retry_nxt;
  logic [DCNT_W-1:0]   r_dcnt, w_dcnt_nxt;

  logic w_idle_like, w_start_acc, w_last, w_is_end, w_is_dly;
  logic w_ack, w_nack, w_can_retry, w_dly_end, w_advance;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_start_acc = start && w_idle_like;
  assign w_last      = &r_rom_addr[IDX_W-1:0];
  assign w_is_end    = (rom_data == END_WORD);
  assign w_is_dly    = (rom_data == DELAY_WORD);
  assign w_ack       = (r_state == S_WAIT_RSP) && rsp_valid && !rsp_nack;
  assign w_nack      = (r_state == S_WAIT_RSP) && rsp_valid && rsp_nack;
  assign w_can_retry = (r_retry < RTRY_W'(MAX_RETRY));
  assign w_dly_end   = (r_state == S_DELAY) && (r_dcnt == '0);
  assign w_advance   = w_ack || w_dly_end;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_reg    <= '0;
      r_cmd_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_fail_index <= '0;
      r_writes_ok  <= '0;
      r_retry      <= '0;
      r_dcnt       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rom_addr   <= w_rom_addr_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_reg    <= w_cmd_reg_nxt;
      r_cmd_data   <= w_cmd_data_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_fail_index <= w_fail_index_nxt;
      r_writes_ok  <= w_writes_ok_nxt;
      r_retry      <= w_retry_nxt;
      r_dcnt       <= w_dcnt_nxt;
    end
  end

  // Next-state logic; the last index ends the run since the index never wraps
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_state_nxt = S_FETCH;
      S_FETCH:                 w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_end)      w_state_nxt = S_DONE;
        else if (w_is_dly) w_state_nxt = S_DELAY;
        else               w_state_nxt = S_SEND;
      end
      S_SEND:     if (cmd_ready) w_state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (w_ack)            w_state_nxt = w_last ? S_DONE : S_FETCH;
        else if (w_nack)      w_state_nxt = w_can_retry ? S_SEND : S_ERROR;
      end
      S_DELAY:    if (w_dly_end) w_state_nxt = w_last ? S_DONE : S_FETCH;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    w_rom_addr_nxt   = r_rom_addr;
    w_cmd_reg_nxt    = r_cmd_reg;
    w_cmd_data_nxt   = r_cmd_data;
    w_fail_index_nxt = r_fail_index;
    w_writes_ok_nxt  = r_writes_ok;
    w_retry_nxt      = r_retry;
    w_dcnt_nxt       = r_dcnt;
    w_cmd_valid_nxt  = (w_state_nxt == S_SEND);
    w_busy_nxt       = !((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                         (w_state_nxt == S_ERROR));
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_error_nxt      = (w_state_nxt == S_ERROR);

    if (w_start_acc) begin
      w_rom_addr_nxt  = {table_sel, IDX_W'(0)};
      w_writes_ok_nxt = '0;
      w_retry_nxt     = '0;
    end
    if (r_state == S_DECODE) begin
      if (w_is_dly) begin
        w_dcnt_nxt = DCNT_W'(DELAY_CYCLES - 1);
      end else if (!w_is_end) begin
        w_cmd_reg_nxt  = rom_data[15:8];
        w_cmd_data_nxt = rom_data[7:0];
      end
    end
    if ((r_state == S_DELAY) && (r_dcnt != '0)) w_dcnt_nxt = r_dcnt - DCNT_W'(1);
    if (w_ack) begin
      w_writes_ok_nxt = r_writes_ok + (IDX_W+1)'(1);
      w_retry_nxt     = '0;
    end
    if (w_nack) begin
      if (w_can_retry) w_retry_nxt      = r_retry + RTRY_W'(1);
      else             w_fail_index_nxt = r_rom_addr[IDX_W-1:0];
    end
    if (w_advance && !w_last)
      w_rom_addr_nxt = {r_rom_addr[ADDR_W-1:IDX_W], r_rom_addr[IDX_W-1:0] + IDX_W'(1)};
  end

  assign rom_addr   = r_rom_addr;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_reg    = r_cmd_reg;
  assign cmd_data   = r_cmd_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign fail_index = r_fail_index;
  assign writes_ok  = r_writes_ok;

endmodule
